// File: rtl/tm1638_driver.sv
// tm1638_driver: TM1638 CLK/DIO PHY; shifts one byte out LSB first or reads the 32-bit key frame into 8 buttons.
// Define TM1638_PROBE_EN to enable the o_probe debug strobe (DIO sample points and write starts).
module tm1638_driver #(
    parameter int CLOCK_FREQ_MHz = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_write_en,
    input  logic [7:0] i_raw_data,
    input  logic       i_read_en,
    output logic [7:0] o_btn_state,
    output logic       o_tm1638_clk,
    inout  wire        io_tm1638_data,
    output logic       o_probe,
    output logic       o_idle
);
    localparam int CW = $clog2(2 * CLOCK_FREQ_MHz + 1);
    localparam logic [CW-1:0] H_END = CW'(CLOCK_FREQ_MHz - 1);
    localparam logic [CW-1:0] P_END = CW'(2 * CLOCK_FREQ_MHz - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ_WAIT, S_READ} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_bit;
    logic [7:0]      r_sh;
    logic [31:0]     r_frame;
    logic [7:0]      r_btn;
    logic            r_clk;
    logic            r_dio;
    logic            r_oe;
`ifdef TM1638_PROBE_EN
    logic            r_probe;
    assign o_probe = r_probe;
`else
    assign o_probe = 1'b0;
`endif

    assign o_tm1638_clk   = r_clk;
    assign io_tm1638_data = r_oe ? r_dio : 1'bz;
    assign o_btn_state    = r_btn;
    assign o_idle         = (r_state == S_IDLE) && !i_write_en && !i_read_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_frame <= '0;
            r_btn   <= '0;
            r_clk   <= 1'b1;
            r_dio   <= 1'b0;
            r_oe    <= 1'b0;
`ifdef TM1638_PROBE_EN
            r_probe <= 1'b0;
`endif
        end else begin
`ifdef TM1638_PROBE_EN
            r_probe <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_write_en) begin
                        r_state <= S_WRITE;
                        r_sh    <= i_raw_data;
                        r_dio   <= i_raw_data[0];
                        r_oe    <= 1'b1;
                        r_clk   <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
`ifdef TM1638_PROBE_EN
                        r_probe <= 1'b1;
`endif
                    end else if (i_read_en) begin
                        r_state <= S_READ_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_WRITE: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == H_END) r_clk <= 1'b1;
                    if (r_cnt == P_END) begin
                        r_cnt <= '0;
                        if (r_bit == 5'd7) begin
                            r_state <= S_IDLE;
                            r_oe    <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                            r_clk <= 1'b0;
                            r_sh  <= r_sh >> 1;
                            r_dio <= r_sh[1];
                        end
                    end
                end
                S_READ_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == P_END) begin
                        r_state <= S_READ;
                        r_clk   <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + CW'(1);
                    // DIO is sampled on the edge that raises CLK; the chip has held it stable since the fall.
                    if (r_cnt == H_END) begin
                        r_clk   <= 1'b1;
                        r_frame <= {io_tm1638_data, r_frame[31:1]};
`ifdef TM1638_PROBE_EN
                        r_probe <= 1'b1;
`endif
                    end
                    if (r_cnt == P_END) begin
                        r_cnt <= '0;
                        if (r_bit == 5'd31) begin
                            r_state <= S_IDLE;
                            r_btn   <= {r_frame[28], r_frame[20], r_frame[12], r_frame[4],
                                        r_frame[24], r_frame[16], r_frame[8], r_frame[0]};
                        end else begin
                            r_bit <= r_bit + 5'd1;
                            r_clk <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tm1638_driver.sv
// tb_tm1638_driver: directed bench for tm1638_driver with a simple TM1638 key-frame model on DIO.
module tb_tm1638_driver;
    localparam int H = 12;
`ifdef TM1638_PROBE_EN
    localparam int PW = 1, PR = 32;
`else
    localparam int PW = 0, PR = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] btn;
    logic       sclk, probe, idle;
    logic       chip_oe = 1'b0, chip_dio = 1'b0;
    wire        dio;

    int         n_chk = 0, n_bad = 0;
    int         busy, nrise, nfall, nprobe, bad_run, wait_hi, dio_err, run, quiet;
    logic       prev;
    logic [7:0] wbits;

    assign dio = chip_oe ? chip_dio : 1'bz;
    always #5 clk = ~clk;

    tm1638_driver #(.CLOCK_FREQ_MHz(H)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_write_en(wr),
        .i_raw_data(data),
        .i_read_en(rd),
        .o_btn_state(btn),
        .o_tm1638_clk(sclk),
        .io_tm1638_data(dio),
        .o_probe(probe),
        .o_idle(idle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] d, input logic both, input int poke);
        @(negedge clk);
        chip_oe = 1'b0; wr = 1'b1; rd = both; data = d;
        #1 chk("wr_req_idle", idle, 0);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        busy = 0; nrise = 0; nprobe = 0; bad_run = 0; wbits = 8'h00; run = 0; prev = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            busy++;
            nprobe += int'(probe);
            if (sclk == prev) run++;
            else begin
                if (run != H) bad_run++;
                if (sclk) begin
                    if (nrise < 8) wbits[nrise[2:0]] = dio;
                    nrise++;
                end
                run = 1;
                prev = sclk;
            end
            rd = (busy == poke);
            @(negedge clk);
        end
        rd = 1'b0;
        chk("wr_busy", busy, 16 * H);
        chk("wr_rises", nrise, 8);
        chk("wr_bits", wbits, d);
        chk("wr_phase_len", bad_run, 0);
        chk("wr_probe", nprobe, PW);
        quiet = 0;
        for (int c = 0; c < 30; c++) begin
            if (!idle || !sclk) quiet++;
            @(negedge clk);
        end
        chk("wr_no_follow", quiet, 0);
        chip_oe = 1'b1; chip_dio = 1'b0;
        #1 chk("wr_release0", dio, 0);
        chip_dio = 1'b1;
        #1 chk("wr_release1", dio, 1);
        chip_oe = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] f, input logic [7:0] exp_btn, input int abort);
        @(negedge clk);
        chip_oe = 1'b1; chip_dio = 1'b0; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        busy = 0; nrise = 0; nfall = 0; nprobe = 0; wait_hi = 0; dio_err = 0; prev = 1'b1;
        for (int c = 0; c < 3000 && !idle; c++) begin
            busy++;
            nprobe += int'(probe);
            if (dio !== chip_dio) dio_err++;
            if (nfall == 0 && sclk) wait_hi++;
            if (!sclk && prev) begin
                if (nfall < 32) chip_dio = f[nfall];
                nfall++;
            end
            if (sclk && !prev) nrise++;
            prev = sclk;
            if (abort > 0 && nrise == abort) begin
                rst = 1'b1;
                #1;
                chk("rst_clk", sclk, 1);
                chk("rst_idle", idle, 1);
                chk("rst_btn", btn, 0);
                chk("rst_probe", probe, 0);
                @(negedge clk);
                rst = 1'b0; chip_oe = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chip_oe = 1'b0;
        chk("rd_busy", busy, 66 * H);
        chk("rd_wait", wait_hi, 2 * H);
        chk("rd_rises", nrise, 32);
        chk("rd_btn", btn, exp_btn);
        chk("rd_probe", nprobe, PR);
        chk("rd_dio_clean", dio_err, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_clk", sclk, 1);
        chk("reset_idle", idle, 1);
        chk("reset_btn", btn, 0);
        chk("reset_probe", probe, 0);
        rst = 1'b0;
        @(negedge clk);
        do_write(8'h8F, 1'b0, -1);
        chk("btn_after_write", btn, 0);
        do_read(32'h01001001, 8'h29, 0);
        do_write(8'h35, 1'b0, 50);
        chk("btn_after_poke", btn, 8'h29);
        do_write(8'hA6, 1'b1, -1);
        do_read(32'h10FF11EE, 8'hE6, 0);
        do_read(32'h01001001, 8'h00, 10);
        do_read(32'h01001001, 8'h29, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
